m_dm: RTL and testbench
=======================

# m_dm

Data memory for the M stage of the five-stage MIPS pipeline. Stores execute on the clock edge; loads read combinationally in the same cycle. The block is addressed by the E-stage ALU result and fed the forwarded rt value. Its load result is M_DMout, which M_W_REG latches for the W stage.

## Interface
Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words, covering byte addresses 0x0000–0x2FFF.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low. reset==0 at a rising edge clears the memory.
- enable  in  1  active-high. When 0, stores are suppressed and loads are unaffected.
- M_PC  in  32  PC of the instruction in M, used only for the write trace.
- M_Instr  in  32  instruction in M. opcode = M_Instr[31:26].
- M_ALUout  in  32  effective byte address.
- M_WD  in  32  store data (forwarded rt).
- M_DMout  out  32  load result, zero/sign-extended; 0 for non-loads.

## Operation
- Opcodes decoded:
  - lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
  - sw 101011, sb 101000, sh 101001.
  - All other opcodes are no-ops and give M_DMout = 0.
- Addressing:
  - idx = M_ALUout[31:2], off = M_ALUout[1:0].
  - In range iff M_ALUout < 4*DEPTH_WORDS.
- Alignment:
  - Word accesses need off==0.
  - Half accesses need off[0]==0.
  - Byte accesses are always aligned.
- Illegal access (out of range or misaligned):
  - Store is dropped: no write, no trace line.
  - Load returns 0.
- Store merge, with be = 4-bit byte enable:
  - sw: be=1111, data=M_WD.
  - sh: be=0011<<off, data={2{M_WD[15:0]}}.
  - sb: be=0001<<off, data={4{M_WD[7:0]}}.
  - Bytes where be=0 keep their old value.
- Load extract from word w = mem[idx]:
  - lw: w.
  - lh/lhu: w[16*off[1]+:16], sign/zero-extended.
  - lb/lbu: w[8*off+:8], sign/zero-extended.
- Write trace: each committed store prints "%d@%h: *%h <= %h" with $time, M_PC, {M_ALUout[31:2],2'b00} and the full merged word. Exactly one line per committed store.

## Timing
- Load latency 0: M_DMout is combinational from the current array contents and M_Instr/M_ALUout.
- Store commits at the rising edge when reset==1 && enable==1 && legal store.
- A load of the same word in the same cycle as a store sees the old value. The new value is visible from the next cycle.
- Reset:
  - At an edge with reset==0, every word becomes 0.
  - Any concurrent store is discarded and produces no trace line.
  - Reset wins over enable.
- Power-on: the array is initialised to 0, matching the post-reset state.
- M_DMout has no register, so it has no independent reset value. During reset it reflects the cleared array (0 after the first reset edge).
- Boundaries:
  - Address 4*DEPTH_WORDS-4 is the last legal word.
  - 4*DEPTH_WORDS is dropped.
  - No wrap-around; addresses are never taken modulo depth.

## Structure
- Shared package mips_pkg:
  - Opcode localparams (OP_LW … OP_SH).
  - DM_DEPTH_WORDS default.
  - Load-type enum {LD_NONE, LD_W, LD_H, LD_HU, LD_B, LD_BU}.
  - The same constants are reused by the D-stage controller and hazard unit.
- One natural sub-module, dm_ext: purely combinational load extraction/extension (word, off, load-type → 32-bit result).
- Decode, byte-enable generation, array and trace stay in m_dm.

## Test plan
- Word store then load: reset pulse, then sw M_WD=0x12345678 @0x0010; next cycle lw @0x0010 → M_DMout=0x12345678. Trace shows addr 0x00000010, data 0x12345678.
- Sub-word stores and loads:
  - After the word above, sb 0xAB @0x0011 → word reads 0x1234AB78.
  - lb @0x0011 → 0xFFFFFFAB; lbu → 0x000000AB.
  - sh 0x8001 @0x0012 → word 0x8001AB78; lh @0x0012 → 0xFFFF8001; lhu → 0x00008001.
- Illegal accesses:
  - sw @0x0013 and sh @0x0011 → memory unchanged, no trace.
  - lw @0x0002 → 0.
  - sw @0x3000 → dropped; lw @0x2FFC after sw 0xCAFEBABE there → 0xCAFEBABE.
- Same-cycle read/write: sw 0x1 @0x20 while lw @0x20 is combinationally sampled → old value 0 that cycle, 0x1 next cycle.
- enable gating: enable=0 with sw 0x55 @0x40 → no write, no trace. lw @0x40 still reads 0.
- Reset mid-operation: memory holding non-zero data, reset=0 coincident with sw 0x77 @0x40 → all words 0, no trace line. After reset=1, lw @0x40 → 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: memory opcodes, data-memory depth and load-type encoding.
// The D-stage controller and the hazard unit use the same decode.
package mips_pkg;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;

   localparam int DM_DEPTH_WORDS = 3072;

   typedef enum logic [2:0] {
      LD_NONE,
      LD_W,
      LD_H,
      LD_HU,
      LD_B,
      LD_BU
   } ld_type_e;

   function automatic ld_type_e ld_decode(input logic [5:0] op);
      case (op)
         OP_LW:   return LD_W;
         OP_LH:   return LD_H;
         OP_LHU:  return LD_HU;
         OP_LB:   return LD_B;
         OP_LBU:  return LD_BU;
         default: return LD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/m_dm_ext.sv
// Load extraction: selects the addressed byte/half of a memory word and sign/zero-extends it.
module dm_ext
   import mips_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  ld_type_e    ld_type,
   output logic [31:0] result
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   always_comb begin
      half_sel = off[1] ? word[31:16] : word[15:0];
      case (off)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase

      result = '0;
      case (ld_type)
         LD_W:    result = word;
         LD_H:    result = {{16{half_sel[15]}}, half_sel};
         LD_HU:   result = {16'h0000, half_sel};
         LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   result = {24'h000000, byte_sel};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/m_dm.sv
// M-stage data memory: edge-triggered byte-enabled stores, combinational loads,
// range/alignment checking and a per-store write trace.
module m_dm
   import mips_pkg::*;
#(
   parameter int DEPTH_WORDS = DM_DEPTH_WORDS
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] M_PC,
   input  logic [31:0] M_Instr,
   input  logic [31:0] M_ALUout,
   input  logic [31:0] M_WD,
   output logic [31:0] M_DMout
);

   localparam int          IW    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

   logic [5:0]    op;
   logic [1:0]    off;
   logic [IW-1:0] word_idx;
   logic          in_range;
   ld_type_e      ld_type;
   logic          ld_align;
   logic [3:0]    be;
   logic [31:0]   st_data;
   logic          st_align;
   logic [31:0]   rd_word;
   logic [31:0]   merged;
   logic [31:0]   ext_word;
   logic          wr_en;
   logic [25:0]   unused_instr_bits;

   assign op                = M_Instr[31:26];
   assign unused_instr_bits = M_Instr[25:0];
   assign off               = M_ALUout[1:0];
   assign word_idx          = M_ALUout[IW+1:2];
   // Full 32-bit compare so high address bits never alias back into the array.
   assign in_range          = M_ALUout < LIMIT;
   assign ld_type           = ld_decode(op);
   assign rd_word           = in_range ? mem[word_idx] : '0;

   always_comb begin
      be       = '0;
      st_data  = '0;
      st_align = 1'b0;
      case (op)
         OP_SW: begin
            be       = 4'b1111;
            st_data  = M_WD;
            st_align = (off == 2'd0);
         end
         OP_SH: begin
            be       = 4'b0011 << off;
            st_data  = {2{M_WD[15:0]}};
            st_align = ~off[0];
         end
         OP_SB: begin
            be       = 4'b0001 << off;
            st_data  = {4{M_WD[7:0]}};
            st_align = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_type)
         LD_W:        ld_align = (off == 2'd0);
         LD_H, LD_HU: ld_align = ~off[0];
         LD_B, LD_BU: ld_align = 1'b1;
         default:     ld_align = 1'b0;
      endcase
   end

   always_comb begin
      merged = rd_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) merged[8*b +: 8] = st_data[8*b +: 8];
      end
   end

   assign wr_en = enable && in_range && st_align && (be != 4'b0000);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[word_idx] <= merged;
         $display("%d@%h: *%h <= %h", $time, M_PC, {M_ALUout[31:2], 2'b00}, merged);
      end
   end

   dm_ext u_ext (
      .word    (rd_word),
      .off     (off),
      .ld_type (ld_type),
      .result  (ext_word)
   );

   assign M_DMout = (in_range && ld_align) ? ext_word : '0;

endmodule

// File: tb/tb_m_dm.sv
// Directed bench for m_dm: the driver queues hand-computed load results, a negedge monitor checks them.
module tb_m_dm;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] M_PC;
   logic [31:0] M_Instr;
   logic [31:0] M_ALUout;
   logic [31:0] M_WD;
   logic [31:0] M_DMout;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   logic        chk_strobe = 1'b0;
   logic        rst_next   = 1'b1;
   int          checks     = 0;
   int          failures   = 0;

   always #5 clk = ~clk;

   m_dm dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .M_PC     (M_PC),
      .M_Instr  (M_Instr),
      .M_ALUout (M_ALUout),
      .M_WD     (M_WD),
      .M_DMout  (M_DMout)
   );

   always @(negedge clk) begin
      if (chk_strobe) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow got=%h required=<queued entry>", M_DMout);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (M_DMout !== e.exp) begin
               failures++;
               $display("FAIL %s got=%h required=%h", e.name, M_DMout, e.exp);
            end
         end
      end
   end

   task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic en, input logic do_chk, input logic [31:0] exp,
                        input string name);
      @(posedge clk);
      #1;
      reset      = rst_next;
      M_Instr    = {op, 26'h0};
      M_ALUout   = addr;
      M_WD       = wd;
      enable     = en;
      M_PC       = M_PC + 32'd4;
      chk_strobe = do_chk;
      if (do_chk) sb_q.push_back('{name, exp});
   endtask

   task automatic ld(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] exp,
                     input string name);
      drive(op, addr, 32'h0, 1'b1, 1'b1, exp, name);
   endtask

   task automatic st(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input string name);
      // M_DMout must read 0 while a store is in M.
      drive(op, addr, wd, 1'b1, 1'b1, 32'h0, name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b0;
      enable   = 1'b1;
      M_PC     = 32'h0000_3000;
      M_Instr  = '0;
      M_ALUout = '0;
      M_WD     = '0;
      repeat (2) @(posedge clk);
      rst_next = 1'b1;

      ld(OP_LW,  32'h10, 32'h0, "reset_lw");
      st(OP_SW,  32'h10, 32'h12345678, "sw_out_zero");
      ld(OP_LW,  32'h10, 32'h12345678, "lw_word");
      st(OP_SB,  32'h11, 32'hFFFF_FFAB, "sb_out_zero");
      ld(OP_LW,  32'h10, 32'h1234AB78, "lw_after_sb");
      ld(OP_LB,  32'h11, 32'hFFFFFFAB, "lb_sign");
      ld(OP_LBU, 32'h11, 32'h000000AB, "lbu_zero");
      st(OP_SH,  32'h12, 32'h0000_8001, "sh_out_zero");
      ld(OP_LW,  32'h10, 32'h8001AB78, "lw_after_sh");
      ld(OP_LH,  32'h12, 32'hFFFF8001, "lh_sign");
      ld(OP_LHU, 32'h12, 32'h00008001, "lhu_zero");
      ld(OP_LB,  32'h13, 32'hFFFFFF80, "lb_off3");
      ld(OP_LBU, 32'h10, 32'h00000078, "lbu_off0");
      ld(OP_LH,  32'h10, 32'hFFFFAB78, "lh_off0");
      ld(6'b000000, 32'h10, 32'h0, "nonload_zero");

      st(OP_SW,  32'h13, 32'hDEADBEEF, "sw_misaligned");
      st(OP_SH,  32'h11, 32'h0000FFFF, "sh_misaligned");
      ld(OP_LW,  32'h10, 32'h8001AB78, "lw_unchanged");
      ld(OP_LH,  32'h11, 32'h0, "lh_misaligned");

      st(OP_SW,  32'h0, 32'h11111111, "sw_word0");
      ld(OP_LW,  32'h2, 32'h0, "lw_misaligned");
      ld(OP_LHU, 32'h2, 32'h00001111, "lhu_off2");

      st(OP_SW,  32'h2FFC, 32'hCAFEBABE, "sw_last");
      st(OP_SW,  32'h3000, 32'h0BADF00D, "sw_oob");
      st(OP_SW,  32'h8000_0010, 32'h0BADF00D, "sw_high_oob");
      ld(OP_LW,  32'h2FFC, 32'hCAFEBABE, "lw_last");
      ld(OP_LB,  32'h2FFF, 32'hFFFFFFCA, "lb_last_byte");
      ld(OP_LW,  32'h3000, 32'h0, "lw_oob");
      ld(OP_LW,  32'h0, 32'h11111111, "no_wrap_word0");
      ld(OP_LW,  32'h10, 32'h8001AB78, "no_wrap_word4");

      // Load samples in the first half of the cycle, then the same slot turns
      // into a store that commits at the coming edge.
      drive(OP_LW, 32'h20, 32'h1, 1'b1, 1'b1, 32'h0, "same_cycle_old");
      @(negedge clk);
      #1;
      M_Instr    = {OP_SW, 26'h0};
      chk_strobe = 1'b0;
      ld(OP_LW,  32'h20, 32'h1, "same_cycle_new");

      drive(OP_SW, 32'h40, 32'h55, 1'b0, 1'b1, 32'h0, "sw_disabled");
      drive(OP_LW, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1, "lw_disabled");
      ld(OP_LW,  32'h40, 32'h0, "lw_after_disabled");

      rst_next = 1'b0;
      st(OP_SW,  32'h40, 32'h77, "sw_during_reset");
      rst_next = 1'b1;
      ld(OP_LW,  32'h40, 32'h0, "post_reset_40");
      ld(OP_LW,  32'h10, 32'h0, "post_reset_10");
      ld(OP_LW,  32'h2FFC, 32'h0, "post_reset_last");
      ld(OP_LW,  32'h0, 32'h0, "post_reset_0");

      drive(6'b000000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "idle");
      repeat (2) @(posedge clk);

      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d required=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
